// File: rtl/mux4_reg.sv
// Registered NUM_IN:1 lane selector with one cycle of latency.
// An out-of-range or unknown select captures zero and raises sel_err.
module mux4_reg #(
    parameter int unsigned DATA_W = 1,
    parameter int unsigned NUM_IN = 4,
    parameter int unsigned SEL_W  = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     en,
    input  logic [NUM_IN*DATA_W-1:0] a,
    input  logic [SEL_W-1:0]         s,
    output logic [DATA_W-1:0]        o,
    output logic                     sel_err
);

    if (NUM_IN < 2 || NUM_IN > 16) begin : g_bad_num_in
        $error("mux4_reg: NUM_IN must be in 2..16");
    end
    if ((2 ** SEL_W) < NUM_IN) begin : g_bad_sel_w
        $error("mux4_reg: SEL_W too narrow for NUM_IN");
    end

    logic [DATA_W-1:0] lane [NUM_IN];
    logic [DATA_W-1:0] o_d, o_q;
    logic              sel_err_d, sel_err_q;

    for (genvar k = 0; k < NUM_IN; k++) begin : g_lane
        assign lane[k] = a[k*DATA_W +: DATA_W];
    end

    // Equality compare per lane: an X/Z select matches nothing and falls to the error value.
    always_comb begin
        o_d       = '0;
        sel_err_d = 1'b1;
        for (int unsigned k = 0; k < NUM_IN; k++) begin
            if (s == SEL_W'(k)) begin
                o_d       = lane[k];
                sel_err_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_q       <= '0;
            sel_err_q <= 1'b0;
        end else if (en) begin
            o_q       <= o_d;
            sel_err_q <= sel_err_d;
        end
    end

    assign o       = o_q;
    assign sel_err = sel_err_q;

    a_sel_known: assert property (@(posedge clk) disable iff (!rst_n) en |-> !$isunknown(s))
        else $error("mux4_reg: unknown select while enabled");

endmodule

// File: tb/tb_mux4_reg.sv
// Scoreboard bench for mux4_reg: a default 4x1-bit instance and a 3x8-bit
// instance share control; the driver queues model results, a monitor checks them.
module tb_mux4_reg;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic [3:0]  a4;
    logic [23:0] a24;
    logic [1:0]  s;
    logic        o1;
    logic        e1;
    logic [7:0]  o8;
    logic        e8;

    mux4_reg u_dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (en),
        .a       (a4),
        .s       (s),
        .o       (o1),
        .sel_err (e1)
    );

    mux4_reg #(.DATA_W(8), .NUM_IN(3), .SEL_W(2)) u_wide (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (en),
        .a       (a24),
        .s       (s),
        .o       (o8),
        .sel_err (e8)
    );

    typedef struct {
        logic       o1;
        logic       e1;
        logic [7:0] o8;
        logic       e8;
    } exp_t;

    exp_t q[$];
    exp_t model;
    int   n_cmp  = 0;
    int   n_fail = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // One clock of stimulus; the model computes what the next rising edge must produce.
    task automatic step(input logic r, input logic e, input logic [3:0] av,
                        input logic [23:0] aw, input logic [1:0] sv);
        @(negedge clk);
        rst_n = r;
        en    = e;
        a4    = av;
        a24   = aw;
        s     = sv;
        if (!r) begin
            model = '{1'b0, 1'b0, 8'h00, 1'b0};
        end else if (e) begin
            model.o1 = av[sv];
            model.e1 = 1'b0;
            if (int'(sv) < 3) begin
                model.o8 = aw[int'(sv)*8 +: 8];
                model.e8 = 1'b0;
            end else begin
                model.o8 = 8'h00;
                model.e8 = 1'b1;
            end
        end
        q.push_back(model);
    endtask

    always @(posedge clk) begin
        exp_t x;
        #1;
        if (q.size() != 0) begin
            x = q.pop_front();
            check("o",        {7'b0, o1}, {7'b0, x.o1});
            check("sel_err",  {7'b0, e1}, {7'b0, x.e1});
            check("o_wide",   o8,         x.o8);
            check("err_wide", {7'b0, e8}, {7'b0, x.e8});
        end
    end

    initial begin
        rst_n = 1'b0;
        en    = 1'b1;
        a4    = 4'b1010;
        a24   = 24'hCCBBAA;
        s     = 2'b01;
        model = '{1'b0, 1'b0, 8'h00, 1'b0};

        #2;
        check("reset_imm_o",   {7'b0, o1}, 8'h00);
        check("reset_imm_err", {7'b0, e1}, 8'h00);

        repeat (3) step(1'b0, 1'b1, 4'b1010, 24'hCCBBAA, 2'b01);
        step(1'b1, 1'b1, 4'b1010, 24'hCCBBAA, 2'b01);

        for (int i = 0; i < 4; i++)
            step(1'b1, 1'b1, 4'b1010, 24'hCCBBAA, 2'(i));

        step(1'b1, 1'b1, 4'b1010, 24'hCCBBAA, 2'b01);
        repeat (3) step(1'b1, 1'b0, 4'b0000, 24'h000000, 2'b00);
        step(1'b1, 1'b1, 4'b0000, 24'h000000, 2'b00);

        step(1'b1, 1'b1, 4'b1010, 24'hDDCCBB, 2'b01);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("async_o",        {7'b0, o1}, 8'h00);
        check("async_err",      {7'b0, e1}, 8'h00);
        check("async_o_wide",   o8,         8'h00);
        model = '{1'b0, 1'b0, 8'h00, 1'b0};
        repeat (2) step(1'b0, 1'b1, 4'b1111, 24'hFFFFFF, 2'b01);

        step(1'b1, 1'b1, 4'b0111, 24'hCCBBAA, 2'b11);
        step(1'b1, 1'b1, 4'b0111, 24'hCCBBAA, 2'b10);
        step(1'b1, 1'b0, 4'b0000, 24'h000000, 2'b11);
        step(1'b1, 1'b1, 4'b0111, 24'hCCBBAA, 2'b11);

        for (int i = 0; i < 300; i++)
            step(($urandom_range(0, 24) != 0), ($urandom_range(0, 3) != 0),
                 4'($urandom), 24'($urandom), 2'($urandom));

        repeat (3) @(posedge clk);
        #2;
        check("queue_drained", 8'(q.size()), 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule
